des_key_schedule: RTL and testbench



---
 rtl/des_pkg.sv | 48 ++++
 rtl/des_pc2.sv | 26 ++
 rtl/des_key_schedule.sv | 138 +++++++++++++
 tb/tb_des_key_schedule.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Purpose  : DES key-schedule tables (PC-1, PC-2, shift schedule), FSM state
//            encoding and 28-bit half rotators.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Entries are 1-based FIPS 46-3 bit positions (bit 1 = MSB).
    localparam int c_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int c_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Index 0 holds shift[1].
    localparam int c_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        return (n == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        return (n == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
// Module   : des_pc2
// Purpose  : Combinational PC-2 permutation, 56-bit C||D -> 48-bit subkey.
// Revision : 1.0 - initial release
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] i_cd,
    output logic [47:0] o_subkey
);

    generate
        for (genvar i = 0; i < 48; i++) begin : g_pc2
            assign o_subkey[47-i] = i_cd[56-c_PC2[i]];
        end
    endgenerate

    // FIPS bits 9,18,22,25,35,38,43,54 are dropped by PC-2.
    logic w_unused_cd;
    assign w_unused_cd = ^{i_cd[47], i_cd[38], i_cd[34], i_cd[31],
                           i_cd[21], i_cd[18], i_cd[13], i_cd[2]};

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Purpose  : Sequential DES key schedule; emits K1..K16 (or K16..K1 when the
//            DES_KS_DECRYPT_EN macro is defined and decrypt=1) via valid/next.
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic        next,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    logic [0:0]  r_state, w_state_nxt;
    logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt;
    logic [3:0]  r_round, w_round_nxt, w_round_inc;
    logic        r_done, w_done_nxt;
    logic        w_dir_in, w_dir, w_last;
    logic [55:0] w_pc1;

    // Key bit p (1-based, MSB first) lives at key[64-p].
    generate
        for (genvar i = 0; i < 56; i++) begin : g_pc1
            assign w_pc1[55-i] = key[64-c_PC1[i]];
        end
    endgenerate

    logic w_unused_parity;
    assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                               key[24], key[16], key[8],  key[0]};

`ifdef DES_KS_DECRYPT_EN
    logic r_dir;
    assign w_dir_in = decrypt;
    assign w_dir    = r_dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= 1'b0;
        end else if (r_state == c_ST_IDLE && load) begin
            r_dir <= decrypt;
        end
    end
`else
    logic w_unused_decrypt;
    assign w_unused_decrypt = decrypt;
    assign w_dir_in = 1'b0;
    assign w_dir    = 1'b0;
`endif

    assign w_round_inc = r_round + 4'd1;
    assign w_last      = w_dir ? (r_round == 4'd0) : (r_round == 4'd15);

    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_round_nxt = r_round;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (load) begin
                    w_state_nxt = c_ST_RUN;
                    if (w_dir_in) begin
                        // C16 = C0, so K16 comes straight from PC-1.
                        w_c_nxt     = w_pc1[55:28];
                        w_d_nxt     = w_pc1[27:0];
                        w_round_nxt = 4'd15;
                    end else begin
                        w_c_nxt     = rotl28(w_pc1[55:28], c_SHIFT[0]);
                        w_d_nxt     = rotl28(w_pc1[27:0], c_SHIFT[0]);
                        w_round_nxt = 4'd0;
                    end
                end
            end
            c_ST_RUN: begin
                if (next) begin
                    if (w_last) begin
                        w_state_nxt = c_ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_round_nxt = 4'd0;
                    end
`ifdef DES_KS_DECRYPT_EN
                    else if (w_dir) begin
                        w_c_nxt     = rotr28(r_c, c_SHIFT[r_round]);
                        w_d_nxt     = rotr28(r_d, c_SHIFT[r_round]);
                        w_round_nxt = r_round - 4'd1;
                    end
`endif
                    else begin
                        w_c_nxt     = rotl28(r_c, c_SHIFT[w_round_inc]);
                        w_d_nxt     = rotl28(r_d, c_SHIFT[w_round_inc]);
                        w_round_nxt = w_round_inc;
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_round <= w_round_nxt;
            r_done  <= w_done_nxt;
        end
    end

    des_pc2 u_pc2 (
        .i_cd     ({r_c, r_d}),
        .o_subkey (subkey)
    );

    assign subkey_valid = (r_state == c_ST_RUN);
    assign busy         = (r_state == c_ST_RUN);
    assign round        = r_round;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_schedule
// Purpose  : Self-checking bench for des_key_schedule against a FIPS-level
//            reference model; honours DES_KS_DECRYPT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst, load, decrypt, next;
    logic [63:0] key;
    logic [47:0] subkey;
    logic        subkey_valid, busy, done;
    logic [3:0]  round;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .key          (key),
        .decrypt      (decrypt),
        .next         (next),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round        (round),
        .busy         (busy),
        .done         (done)
    );

    int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                       10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                       16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                       44,49,39,56,34,53, 46,42,50,36,29,32};
    int sh_t  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // Kr straight from the FIPS definition: C0,D0 rotated by the cumulative shift.
    function automatic logic [47:0] subkey_of(input logic [63:0] k, input int r);
        logic [55:0] cd, cdr;
        logic [27:0] c, d;
        logic [47:0] sk;
        int tot;
        for (int i = 1; i <= 56; i++) cd[56-i] = k[64-pc1_t[i-1]];
        c = cd[55:28];
        d = cd[27:0];
        tot = 0;
        for (int j = 0; j < r; j++) tot += sh_t[j];
        for (int j = 0; j < tot; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cdr = {c, d};
        for (int i = 1; i <= 48; i++) sk[48-i] = cdr[56-pc2_t[i-1]];
        return sk;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks how many subkeys were accepted in the current run.
    logic dec_eff;
`ifdef DES_KS_DECRYPT_EN
    assign dec_eff = decrypt;
`else
    assign dec_eff = 1'b0;
`endif

    bit          m_run, m_dir, m_done, m_zero;
    int          m_cnt;
    logic [63:0] m_key;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_run  <= 1'b0;
            m_dir  <= 1'b0;
            m_cnt  <= 0;
            m_zero <= 1'b1;
        end else if (!m_run) begin
            if (load) begin
                m_run  <= 1'b1;
                m_dir  <= dec_eff;
                m_key  <= key;
                m_cnt  <= 0;
                m_zero <= 1'b0;
            end
        end else if (next) begin
            if (m_cnt == 15) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int er;
            er = m_dir ? 15 - m_cnt : m_cnt;
            chk("valid", subkey_valid, m_run);
            chk("busy", busy, m_run);
            chk("done", done, m_done);
            chk("round", round, m_run ? er : 0);
            if (m_run)       chk("subkey", subkey, subkey_of(m_key, er + 1));
            else if (m_zero) chk("subkey_rst", subkey, 0);
        end
    end

    localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_P = 64'h123456789ABCDEF0;
    localparam logic [47:0] K1    = 48'h1B02EFFC7072;
    localparam logic [47:0] K2    = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16   = 48'hCB3D8B0E17F5;

    task automatic do_load(input logic [63:0] k, input logic dec);
        load    = 1'b1;
        key     = k;
        decrypt = dec;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; load = 1'b0; key = '0; decrypt = 1'b0; next = 1'b0;
        repeat (2) @(negedge clk);
        started = 1'b1;
        chk("reset_valid", subkey_valid, 0);
        chk("reset_subkey", subkey, 0);
        rst = 1'b0;

        // Encrypt, next held high.
        next = 1'b1;
        do_load(KEY, 1'b0);
        chk("enc_k1", subkey, K1);
        chk("enc_r0", round, 0);
        @(negedge clk);
        chk("enc_k2", subkey, K2);
        repeat (14) @(negedge clk);
        chk("enc_k16", subkey, K16);
        chk("enc_r15", round, 15);
        @(negedge clk);
        chk("enc_done", done, 1);

        // Decrypt restarted back-to-back in the done cycle.
        do_load(KEY, 1'b1);
`ifdef DES_KS_DECRYPT_EN
        chk("dec_first", subkey, K16);
`else
        chk("dec_first", subkey, K1);
`endif
        repeat (15) @(negedge clk);
`ifdef DES_KS_DECRYPT_EN
        chk("dec_last", subkey, K1);
`else
        chk("dec_last", subkey, K16);
`endif
        @(negedge clk);
        chk("dec_done", done, 1);
        next = 1'b0;
        repeat (2) @(negedge clk);

        // Stall at round 3 with a foreign load attempted meanwhile.
        next = 1'b1;
        do_load(KEY, 1'b0);
        repeat (3) @(negedge clk);
        next = 1'b0;
        load = 1'b1;
        key  = 64'hFEDCBA9876543210;
        repeat (5) @(negedge clk);
        load = 1'b0;
        chk("stall_round", round, 3);
        chk("stall_subkey", subkey, subkey_of(KEY, 4));
        next = 1'b1;
        @(negedge clk);
        chk("stall_release", round, 4);
        repeat (12) @(negedge clk);
        next = 1'b0;
        @(negedge clk);

        // Reset at round 7, then restart.
        next = 1'b1;
        do_load(KEY, 1'b0);
        repeat (7) @(negedge clk);
        chk("pre_rst_round", round, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", subkey_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_subkey", subkey, 0);
        chk("rst_nodone", done, 0);
        do_load(KEY, 1'b0);
        chk("restart_round", round, 0);
        chk("restart_k1", subkey, K1);
        repeat (16) @(negedge clk);

        // Parity bits flipped: identical schedule.
        do_load(KEY_P, 1'b0);
        chk("parity_k1", subkey, K1);
        repeat (15) @(negedge clk);
        chk("parity_k16", subkey, K16);
        @(negedge clk);

        // Randomised traffic against the model.
        for (int n = 0; n < 40; n++) begin
            do_load({$urandom, $urandom}, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 40; c++) begin
                next    = ($urandom_range(0, 3) != 0);
                load    = ($urandom_range(0, 7) == 0);
                key     = {$urandom, $urandom};
                decrypt = 1'($urandom_range(0, 1));
                rst     = ($urandom_range(0, 99) == 0);
                @(negedge clk);
            end
            rst  = 1'b0;
            load = 1'b0;
            next = 1'b1;
            repeat (18) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
